chord_arpeggiator: RTL

Registered, parametrised successor to the combinational chord-to-notes decoder. It accepts a scale-degree chord and key over a valid/ready handshake and computes the diatonic seventh (or triad) voicing into a registered packed bus. It can then replay the voicing as a timed single-note stream in up, down or up-down arpeggio order. It sits between chord selection logic and the tone generator.

---
 rtl/chord_arpeggiator.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/chord_arpeggiator.sv
// Registered chord-to-voicing decoder with a timed up/down/up-down arpeggio player.
// state | meaning: IDLE wait for request, CALC register voicing, PLAY step through notes
module chord_arpeggiator #(
  parameter int NUM_NOTES = 4,
  parameter int NOTE_W    = 4,
  parameter int STEP_DIV  = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [3:0]                  chord,
  input  logic [3:0]                  key,
  input  logic [1:0]                  mode,
  input  logic                        chord_valid,
  output logic                        chord_ready,
  input  logic                        stop,
  output logic [NUM_NOTES*NOTE_W-1:0] notes_for_chord,
  output logic                        chord_done,
  output logic [NOTE_W-1:0]           note_out,
  output logic                        note_valid,
  output logic                        busy
);

  localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int PW = 3;
  localparam logic [CW-1:0] CNT_RELOAD = CW'(STEP_DIV - 1);
  localparam logic [PW-1:0] LAST_UP    = PW'(NUM_NOTES - 1);
  localparam logic [PW-1:0] LAST_UD    = PW'(2 * NUM_NOTES - 3);
  localparam logic [PW-1:0] SPAN_UD    = PW'(2 * NUM_NOTES - 2);

  typedef enum logic [1:0] {IDLE, CALC, PLAY} state_t;

  state_t                        state;
  logic [3:0]                    chord_q, key_q;
  logic [1:0]                    mode_q;
  logic [PW-1:0]                 pos;
  logic [CW-1:0]                 cnt;
  logic [NUM_NOTES*NOTE_W-1:0]   notes_q;
  logic [NUM_NOTES*NOTE_W-1:0]   voicing;
  logic [NOTE_W-1:0]             slot [8];
  logic [PW-1:0]                 voice_idx, pos_next;
  logic [5:0]                    root, base;
  logic [5:0]                    ivs [4];
  logic                          rest, accept;
  logic [3:0]                    key_mod;

  function automatic logic [NOTE_W-1:0] wrap12(input logic [5:0] s);
    if (s >= 6'd24)      return NOTE_W'(s - 6'd24);
    else if (s >= 6'd12) return NOTE_W'(s - 6'd12);
    else                 return NOTE_W'(s);
  endfunction

  assign chord_ready = reset_n & ~stop & (state == IDLE || state == PLAY);
  assign accept      = chord_valid & chord_ready;
  assign busy        = (state == CALC) || (state == PLAY);
  assign key_mod     = (key >= 4'd12) ? key - 4'd12 : key;
  assign rest        = (chord_q == 4'd0) || chord_q[3];
  assign notes_for_chord = notes_q;

  // Root offset and interval set per scale degree
  always_comb begin
    root   = 6'd0;
    ivs[0] = 6'd0;
    ivs[1] = 6'd3;
    ivs[2] = 6'd7;
    ivs[3] = 6'd10;
    case (chord_q)
      4'd1: begin root = 6'd0;  ivs[1] = 6'd4; ivs[3] = 6'd11; end
      4'd2: root = 6'd2;
      4'd3: root = 6'd4;
      4'd4: begin root = 6'd5;  ivs[1] = 6'd4; ivs[3] = 6'd11; end
      4'd5: begin root = 6'd7;  ivs[1] = 6'd4; end
      4'd6: root = 6'd9;
      4'd7: begin root = 6'd11; ivs[2] = 6'd6; end
      default: root = 6'd0;
    endcase
    base    = {2'b00, key_q} + root;
    voicing = '0;
    if (!rest) begin
      for (int i = 0; i < NUM_NOTES; i++)
        voicing[(NUM_NOTES-1-i)*NOTE_W +: NOTE_W] = wrap12(base + ivs[i]);
    end
  end

  always_comb begin
    for (int i = 0; i < 8; i++) slot[i] = '0;
    for (int i = 0; i < NUM_NOTES; i++) slot[i] = notes_q[(NUM_NOTES-1-i)*NOTE_W +: NOTE_W];
  end

  // Up-down folds the position back so the endpoints play once per period
  always_comb begin
    case (mode_q)
      2'd2:    voice_idx = LAST_UP - pos;
      2'd3:    voice_idx = (pos > LAST_UP) ? SPAN_UD - pos : pos;
      default: voice_idx = pos;
    endcase
    if (mode_q == 2'd3) pos_next = (pos == LAST_UD) ? '0 : pos + 1'b1;
    else                pos_next = (pos == LAST_UP) ? '0 : pos + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      chord_q    <= '0;
      key_q      <= '0;
      mode_q     <= '0;
      pos        <= '0;
      cnt        <= '0;
      notes_q    <= '0;
      chord_done <= 1'b0;
      note_out   <= '0;
      note_valid <= 1'b0;
    end else begin
      chord_done <= 1'b0;
      note_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            chord_q <= chord;
            key_q   <= key_mod;
            mode_q  <= mode;
            state   <= CALC;
          end
        end
        CALC: begin
          notes_q    <= voicing;
          chord_done <= 1'b1;
          pos        <= '0;
          cnt        <= '0;
          if (rest || mode_q == 2'd0) begin
            state    <= IDLE;
            note_out <= '0;
          end else begin
            state    <= PLAY;
          end
        end
        PLAY: begin
          if (stop) begin
            state    <= IDLE;
            note_out <= '0;
          end else if (accept) begin
            chord_q <= chord;
            key_q   <= key_mod;
            mode_q  <= mode;
            state   <= CALC;
          end else if (cnt == '0) begin
            note_valid <= 1'b1;
            note_out   <= slot[voice_idx];
            pos        <= pos_next;
            cnt        <= CNT_RELOAD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
